// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_queue
// Description : Sequential instruction prefetcher. Issues one word fetch at a
//               time over a req/ack handshake, buffers returned words and
//               their PCs in a DEPTH-entry FIFO, and presents the oldest entry
//               to decode over valid/ready. A redirect flushes the queue and
//               restarts fetching at the target PC.
//               Optional macro PREFETCH_BYPASS_EN: forwards a returning word
//               straight to decode when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] ins_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        fetch_pc;
    logic [31:0]        req_addr;
    logic [CNT_W-1:0]   count;
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [31:0]        q_data [DEPTH];
    logic [31:0]        q_pc   [DEPTH];

    logic               start_req;
    logic               fetch_done;
    logic               head_valid;
    logic               enq;
    logic               deq;

    // A slot is reserved when the request starts, so the enqueue can never overflow.
    assign start_req  = (state == IDLE) && !redirect_valid && (count < CNT_W'(DEPTH));
    // Only a live (non-draining) request delivers a word into the queue.
    assign fetch_done = (state == REQ) && mem_ack;
    assign head_valid = (count != '0);
    assign deq        = head_valid && ins_ready && !redirect_valid;
    assign mem_addr   = req_addr;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass = (count == '0) && fetch_done && !redirect_valid;
    // Empty queue: the returning word is shown to decode in its ack cycle.
    always_comb begin
        ins_valid   = head_valid || bypass;
        INSTRUCTION = 32'h0;
        ins_pc      = 32'h0;
        if (head_valid) begin
            INSTRUCTION = q_data[head];
            ins_pc      = q_pc[head];
        end else if (bypass) begin
            INSTRUCTION = mem_rdata;
            ins_pc      = req_addr;
        end
    end
    assign enq = fetch_done && !redirect_valid && !(bypass && ins_ready);
`else
    // Head entry drives decode; zeros when the queue is empty.
    always_comb begin
        ins_valid   = head_valid;
        INSTRUCTION = 32'h0;
        ins_pc      = 32'h0;
        if (head_valid) begin
            INSTRUCTION = q_data[head];
            ins_pc      = q_pc[head];
        end
    end
    assign enq = fetch_done && !redirect_valid;
`endif

    // Fetch state register; async reset drops mem_req immediately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and request strobe.
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        case (state)
            IDLE: begin
                if (start_req) state_nxt = REQ;
            end
            REQ: begin
                mem_req = 1'b1;
                if (mem_ack)             state_nxt = IDLE;
                else if (redirect_valid) state_nxt = DRAIN;
            end
            DRAIN: begin
                mem_req = 1'b1;
                if (mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Fetch PC and the address latched for the outstanding request.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (redirect_valid)  fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            else if (fetch_done) fetch_pc <= fetch_pc + 32'd4;
            if (start_req)       req_addr <= fetch_pc;
        end
    end

    // Queue occupancy and pointers; redirect clears everything.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else if (redirect_valid) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            if (enq && !deq)      count <= count + CNT_W'(1);
            else if (!enq && deq) count <= count - CNT_W'(1);
        end
    end

    // Queue storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge CLK) begin
        if (enq) begin
            q_data[tail] <= mem_rdata;
            q_pc[tail]   <= req_addr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_prefetch_queue
// Description : Self-checking bench for instr_prefetch_queue: transaction
//               level reference model compared every cycle, plus directed
//               scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] XORK     = 32'hA5A5_0000;

    logic        CLK;
    logic        RESET;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] INSTRUCTION;
    logic [31:0] ins_pc;

    instr_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK(CLK), .RESET(RESET),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .INSTRUCTION(INSTRUCTION), .ins_pc(ins_pc)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    ent_t        mq[$];
    bit          m_busy  = 1'b0;   // a request is on the bus
    bit          m_stale = 1'b0;   // that request predates a redirect
    logic [31:0] m_addr  = RESET_PC;
    logic [31:0] m_pc    = RESET_PC;

    task automatic model_reset();
        mq.delete();
        m_busy  = 1'b0;
        m_stale = 1'b0;
        m_addr  = RESET_PC;
        m_pc    = RESET_PC;
    endtask

    task automatic model_step();
        bit ack;
        bit byp;
        int n;
        ack = m_busy && mem_ack;
        byp = 1'b0;
        n   = mq.size();
        if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            if (ack) begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end else if (m_busy) begin
                m_stale = 1'b1;
            end
        end else begin
`ifdef PREFETCH_BYPASS_EN
            byp = (n == 0) && ack && !m_stale && ins_ready;
`endif
            if (n != 0 && ins_ready) void'(mq.pop_front());
            if (ack) begin
                if (!m_stale) begin
                    if (!byp) mq.push_back('{pc: m_addr, data: mem_rdata});
                    m_pc = m_pc + 32'd4;
                end
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end else if (!m_busy && n < DEPTH) begin
                m_busy = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) model_reset();
            else       model_step();
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic [31:0] popped[$];
    int          fetch_cnt = 0;

    initial begin
        forever begin
            logic        ev;
            logic [31:0] ei;
            logic [31:0] ep;
            @(negedge CLK);
            ev = (mq.size() != 0);
            ei = ev ? mq[0].data : 32'h0;
            ep = ev ? mq[0].pc   : 32'h0;
`ifdef PREFETCH_BYPASS_EN
            if (!ev && m_busy && !m_stale && mem_ack && !redirect_valid && !RESET) begin
                ev = 1'b1;
                ei = mem_rdata;
                ep = m_addr;
            end
`endif
            check("mem_req", mem_req, m_busy);
            if (m_busy || RESET) check("mem_addr", mem_addr, m_addr);
            check("ins_valid", ins_valid, ev);
            check("INSTRUCTION", INSTRUCTION, ei);
            check("ins_pc", ins_pc, ep);
            if (ins_valid && ins_ready && !redirect_valid) popped.push_back(ins_pc);
            if (mem_req && mem_ack) fetch_cnt++;
        end
    end

    // ---------------- memory responder ----------------
    int          ack_delay  = 1;
    bit          ack_fixed  = 1'b0;
    logic [31:0] fixed_data = 32'h0;

    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge CLK);
            #1;
            if (RESET || !mem_req) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (wcnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = ack_fixed ? fixed_data : (mem_addr ^ XORK);
            end else begin
                wcnt++;
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        #1 RESET = 1'b1;
        redirect_valid = 1'b0;
        repeat (2) @(negedge CLK);
        fetch_cnt = 0;
        popped.delete();
        #1 RESET = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        bit ok;
        RESET          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ins_ready      = 1'b0;

        repeat (2) @(negedge CLK);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_addr", mem_addr, RESET_PC);
        check("rst_ins_valid", ins_valid, 1'b0);
        check("rst_instruction", INSTRUCTION, 32'h0);
        check("rst_ins_pc", ins_pc, 32'h0);

        // 1: streaming with decode always ready
        ins_ready = 1'b1;
        popped.delete();
        #1 RESET = 1'b0;
        repeat (30) @(negedge CLK);
        check("t1_pop_count", popped.size() >= 4, 1'b1);
        if (popped.size() >= 4)
            for (int i = 0; i < 4; i++) check("t1_pc_order", popped[i], 32'(i * 4));

        // 2: decode stalled, queue fills then a single pop frees one slot
        ins_ready = 1'b0;
        do_reset();
        repeat (40) @(negedge CLK);
        check("t2_fetch_count", fetch_cnt, 4);
        check("t2_no_req_full", mem_req, 1'b0);
        check("t2_head_pc", ins_pc, 32'h0);
        check("t2_head_word", INSTRUCTION, XORK);
        #1 ins_ready = 1'b1;
        @(negedge CLK);
        #1 ins_ready = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 3 && !ok; k++) begin
            @(negedge CLK);
            ok = mem_req;
        end
        check("t2_refetch_seen", ok, 1'b1);
        check("t2_refetch_addr", mem_addr, 32'h10);
        check("t2_new_head_pc", ins_pc, 32'h4);

        // 3: redirect while the 0x10 request is outstanding
        ins_ready = 1'b1;
        ack_delay = 3;
        do_reset();
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge CLK);
            ok = mem_req && (mem_addr == 32'h10);
        end
        check("t3_req10_seen", ok, 1'b1);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h27;
        @(negedge CLK);
        check("t3_drain_req", mem_req, 1'b1);
        check("t3_drain_addr", mem_addr, 32'h10);
        #1 redirect_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge CLK);
            ok = mem_req && (mem_addr != 32'h10);
        end
        check("t3_next_req_seen", ok, 1'b1);
        check("t3_next_addr", mem_addr, 32'h24);
        ok = 1'b0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge CLK);
            ok = ins_valid;
        end
        check("t3_valid_seen", ok, 1'b1);
        check("t3_first_pc", ins_pc, 32'h24);
        check("t3_first_word", INSTRUCTION, 32'h24 ^ XORK);

        // 4: redirect coinciding with an ack, queue non-empty
        ins_ready = 1'b0;
        ack_delay = 1;
        do_reset();
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge CLK);
            ok = ins_valid && mem_ack;
        end
        check("t4_setup_seen", ok, 1'b1);
        #1 redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge CLK);
        check("t4_flushed", ins_valid, 1'b0);
        #1 redirect_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge CLK);
            ok = mem_req;
        end
        check("t4_req_seen", ok, 1'b1);
        check("t4_target_addr", mem_addr, 32'h100);

        // 5: asynchronous reset in the middle of a request
        ins_ready = 1'b0;
        ack_delay = 3;
        do_reset();
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge CLK);
            ok = mem_req && ins_valid;
        end
        check("t5_setup_seen", ok, 1'b1);
        #2 RESET = 1'b1;
        #1;
        check("t5_async_mem_req", mem_req, 1'b0);
        check("t5_async_valid", ins_valid, 1'b0);
        check("t5_async_instr", INSTRUCTION, 32'h0);
        check("t5_async_pc", ins_pc, 32'h0);
        @(negedge CLK);
        #1 RESET = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge CLK);
            ok = mem_req;
        end
        check("t5_req_seen", ok, 1'b1);
        check("t5_first_addr", mem_addr, RESET_PC);

        // 6: ack into an empty queue with decode ready
        ins_ready  = 1'b1;
        ack_delay  = 1;
        ack_fixed  = 1'b1;
        fixed_data = 32'h012A_4020;
        do_reset();
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge CLK);
            ok = mem_ack;
        end
        check("t6_ack_seen", ok, 1'b1);
`ifdef PREFETCH_BYPASS_EN
        check("t6_bypass_valid", ins_valid, 1'b1);
        check("t6_bypass_word", INSTRUCTION, 32'h012A_4020);
        check("t6_bypass_pc", ins_pc, 32'h0);
        @(negedge CLK);
        check("t6_not_enqueued", ins_valid, 1'b0);
`else
        check("t6_ack_cycle_valid", ins_valid, 1'b0);
        @(negedge CLK);
        check("t6_next_valid", ins_valid, 1'b1);
        check("t6_next_word", INSTRUCTION, 32'h012A_4020);
        check("t6_next_pc", ins_pc, 32'h0);
`endif
        ack_fixed = 1'b0;

        repeat (5) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
Instruction fetch front end sitting directly upstream of the instruction register. It issues sequential word fetches to instruction memory over a req/ack handshake and buffers the returned words with their PCs in a small FIFO. It presents the oldest word to the decode side with a valid/ready handshake. A branch/jump redirect flushes the queue and restarts fetching at the target PC.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
RESET_PC, 32'h0, first fetch address after reset

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  reset, asynchronous, active-high
redirect_valid  input  1  flush the queue and restart fetch at redirect_pc
redirect_pc  input  32  redirect target; bits [1:0] ignored and treated as 0
mem_req  output  1  fetch request to instruction memory
mem_addr  output  32  byte address of the requested word; word-aligned
mem_ack  input  1  fetch completes on a posedge where mem_req && mem_ack
mem_rdata  input  32  fetched word; valid when mem_ack is high
ins_valid  output  1  queue head is valid
ins_ready  input  1  decode accepts the head
INSTRUCTION  output  32  head instruction word; 32'h0 when ins_valid=0
ins_pc  output  32  PC of the head word; 32'h0 when ins_valid=0

Behaviour:
- One clock domain, CLK. RESET is asynchronous and active-high.
- Reset values:
  - Outputs: mem_req=0, mem_addr=RESET_PC, ins_valid=0, INSTRUCTION=0, ins_pc=0.
  - Internal: fetch_pc=RESET_PC, count=0, state=IDLE.
- count width is clog2(DEPTH+1). Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Three states:
  - IDLE: mem_req=0. Moves to REQ on the next posedge if count < DEPTH and redirect_valid=0.
  - REQ: mem_req=1, mem_addr=fetch_pc, both held stable until ack.
    - On ack: word and PC are enqueued, fetch_pc += 4 (wraps mod 2^32), state goes to IDLE. One idle cycle between requests is required.
  - DRAIN: a redirect arrived while a request was outstanding.
    - mem_req stays 1 and mem_addr stays at the old address until ack.
    - The acked data is discarded. State then goes to IDLE.
- Only one request is outstanding at a time. A slot is reserved on entry to REQ, so an enqueue never overflows.
- Dequeue occurs on a posedge with ins_valid && ins_ready: head advances and count decrements.
- Simultaneous enqueue and dequeue in one cycle leaves count unchanged and keeps order intact.
- ins_valid = (count != 0). INSTRUCTION and ins_pc are driven combinationally from the head entry.
- Redirect (posedge with redirect_valid=1) takes priority over everything else:
  - count, head and tail are cleared. A same-cycle dequeue or enqueue is dropped.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - From REQ without ack: state goes to DRAIN.
  - From REQ with ack in the same cycle: data is discarded, state goes to IDLE.
  - From DRAIN: fetch_pc is updated and state stays DRAIN. If ack arrives that same cycle, state goes to IDLE.
  - From IDLE: state stays IDLE.
- ins_valid never asserts for a word fetched before the most recent redirect.
- RESET asserted mid-transaction: mem_req drops immediately, without waiting for a clock edge. Instruction memory must tolerate an abandoned request.
- Full queue: no new request is issued while count = DEPTH, whatever the state of ins_ready.

Optional Feature:
Macro PREFETCH_BYPASS_EN.
- Defined: when count = 0, state = REQ, mem_ack = 1 and redirect_valid = 0, then:
  - ins_valid=1, INSTRUCTION=mem_rdata and ins_pc=mem_addr, driven combinationally.
  - If ins_ready=1 the word is consumed and not enqueued. Otherwise it is enqueued normally.
  - Ack-to-decode latency is 0 cycles.
- Not defined: a returned word is visible at the earliest one cycle after its ack (latency 1). No combinational path exists from mem_ack or mem_rdata to the outputs.

Test Plan:
1. Reset release; memory acks each request one cycle after mem_req with rdata = addr ^ 32'hA5A50000; ins_ready=1 -> ins_pc sequence 0,4,8,12 in order with INSTRUCTION matching; mem_addr only ever increments by 4.
2. ins_ready=0, DEPTH=4 -> exactly four fetches (0x0..0xC), then mem_req stays 0. Pulse ins_ready one cycle -> head 0x0 popped, next mem_req for 0x10 asserts within 2 cycles.
3. Request to 0x10 outstanding (ack delayed 3 cycles) when redirect_valid with redirect_pc=0x27 is applied -> mem_addr holds 0x10 until ack; that data never appears; next request is mem_addr=0x24; ins_valid=0 between redirect and the 0x24 data.
4. redirect_valid and mem_ack in the same cycle with a non-empty queue -> count=0 next cycle, acked word dropped, next mem_addr = redirect target.
5. RESET asserted between clock edges while in REQ -> mem_req, ins_valid, INSTRUCTION and ins_pc go to 0 before the next posedge; after release the first mem_addr = RESET_PC.
6. With PREFETCH_BYPASS_EN, empty queue, ins_ready=1, ack with rdata=32'h012A4020 -> ins_valid=1 and INSTRUCTION=32'h012A4020 in the ack cycle; count stays 0. Without the macro -> ins_valid rises the cycle after the ack.
